uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_fifo.sv | 39 +++
 rtl/uart_tx.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity mode constants and data width
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic [31:0] PAR_NONE = "NONE";
  localparam logic [31:0] PAR_EVEN = "EVEN";
  localparam logic [31:0] PAR_ODD = "ODD";
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO with wrap-bit pointers
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    pop_data = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter stepping one line bit per tx_bd_en pulse
module uart_tx import uart_pkg::*; #(
  parameter logic [31:0] PARITY = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_bd_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam logic HAS_PAR = PARITY != PAR_NONE;
  localparam logic ODD = PARITY == PAR_ODD;
  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d, head;
  logic [2:0] bit_q, bit_d;
  logic stop_q, stop_d, tx_q, tx_d, pop, full, empty, last_stop;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(tx_valid),
    .push_data(tx_data),
    .pop(pop),
    .pop_data(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    bit_d = bit_q;
    stop_d = stop_q;
    tx_d = tx_q;
    pop = 1'b0;
    last_stop = int'(stop_q) == STOP_BITS - 1;
    if (tx_bd_en) begin
      case (state_q)
        ST_IDLE, ST_STOP: begin
          if (state_q == ST_IDLE || last_stop) begin
            stop_d = 1'b0;
            pop = !empty;
            data_d = empty ? data_q : head;
            tx_d = empty;
            state_d = empty ? ST_IDLE : ST_START;
          end else stop_d = 1'b1;
        end
        ST_START: begin
          tx_d = data_q[0];
          bit_d = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          bit_d = bit_q + 3'd1;
          tx_d = bit_q == 3'd7 ? (HAS_PAR ? (^data_q) ^ ODD : 1'b1) : data_q[bit_q + 3'd1];
          state_d = bit_q != 3'd7 ? ST_DATA : HAS_PAR ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          tx_d = 1'b1;
          state_d = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q <= '0;
      bit_q <= '0;
      stop_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      bit_q <= bit_d;
      stop_q <= stop_d;
      tx_q <= tx_d;
    end
  end
  assign tx = tx_q;
  assign tx_ready = !full;
  assign tx_busy = state_q != ST_IDLE || !empty;
endmodule
